fifo_burst_packer: RTL and testbench

FIFO_BURST_PACKER -- requirements
Module: fifo_burst_packer

---
 rtl/fifo_burst_packer_if.sv | 33 +++
 rtl/fifo_burst_packer.sv | 103 ++++++++++
 tb/tb_fifo_burst_packer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_packer_if.sv
// ============================================================================
// Module   : fifo_burst_packer_if
// Purpose  : Upstream FWFT FIFO, flush and downstream burst signals of the packer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_burst_packer_if #(
    parameter int DWIDTH    = 64,
    parameter int BURST_LEN = 4
);
    logic                        fifo_valid;
    logic [DWIDTH-1:0]           fifo_data;
    logic                        fifo_deque_en;
    logic                        flush;
    logic                        m_valid;
    logic                        m_ready;
    logic [BURST_LEN*DWIDTH-1:0] m_data;
    logic [BURST_LEN-1:0]        m_keep;
    logic [31:0]                 burst_cnt;

    modport master (
        input  fifo_valid, fifo_data, flush, m_ready,
        output fifo_deque_en, m_valid, m_data, m_keep, burst_cnt
    );

    modport slave (
        output fifo_valid, fifo_data, flush, m_ready,
        input  fifo_deque_en, m_valid, m_data, m_keep, burst_cnt
    );
endinterface

`default_nettype wire

// File: rtl/fifo_burst_packer.sv
// ============================================================================
// Module   : fifo_burst_packer
// Purpose  : Packs FWFT FIFO words into BURST_LEN-lane bursts with flush/timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_burst_packer #(
    parameter int DWIDTH    = 64,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fifo_burst_packer_if.master bus
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int IW = $clog2(TIMEOUT);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               word_cnt_q, word_cnt_d;
    logic [IW-1:0]               idle_q, idle_d;
    logic [BURST_LEN*DWIDTH-1:0] data_q, data_d;
    logic [BURST_LEN-1:0]        keep_q, keep_d;
    logic [31:0]                 burst_cnt_q, burst_cnt_d;
    logic                        pop;

    assign pop               = (state_q == FILL) && bus.fifo_valid;
    assign bus.fifo_deque_en = pop;
    assign bus.m_valid       = (state_q == HOLD);
    assign bus.m_data        = data_q;
    assign bus.m_keep        = keep_q;
    assign bus.burst_cnt     = burst_cnt_q;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        idle_d      = idle_q;
        data_d      = data_q;
        keep_d      = keep_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            FILL: begin
                if (pop) begin
                    for (int i = 0; i < BURST_LEN; i++) begin
                        if (word_cnt_q == CW'(i)) begin
                            data_d[i*DWIDTH +: DWIDTH] = bus.fifo_data;
                            keep_d[i]                  = 1'b1;
                        end
                    end
                    word_cnt_d = word_cnt_q + CW'(1);
                    idle_d     = '0;
                    // A flush on the completing pop still yields a single full burst.
                    if ((word_cnt_d == CW'(BURST_LEN)) || bus.flush) begin
                        state_d = HOLD;
                    end
                end else if (word_cnt_q != '0) begin
                    if (bus.flush || (idle_q == IW'(TIMEOUT - 1))) begin
                        state_d = HOLD;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    burst_cnt_d = burst_cnt_q + 32'd1;
                    word_cnt_d  = '0;
                    idle_d      = '0;
                    data_d      = '0;
                    keep_d      = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            word_cnt_q  <= '0;
            idle_q      <= '0;
            data_q      <= '0;
            keep_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            idle_q      <= idle_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_packer.sv
// ============================================================================
// Module   : tb_fifo_burst_packer
// Purpose  : Directed and randomized checks of fifo_burst_packer against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_burst_packer;
    localparam int DW = 64;
    localparam int BL = 4;
    localparam int TO = 16;
    localparam int W  = BL * DW;

    logic clk;
    logic rst_n;

    fifo_burst_packer_if #(.DWIDTH(DW), .BURST_LEN(BL)) bus ();

    fifo_burst_packer #(
        .DWIDTH   (DW),
        .BURST_LEN(BL),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: upstream FIFO contents, buffered burst words, presentation flag.
    logic [DW-1:0] src[$];
    logic [DW-1:0] pk[$];
    bit            hold;
    logic [31:0]   cnt;
    int            edge_n;
    int            last_pop;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BL-1:0] exp_keep();
        logic [BL-1:0] k = '0;
        for (int i = 0; i < pk.size(); i++) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [W-1:0] exp_data();
        logic [W-1:0] d = '0;
        for (int i = 0; i < pk.size(); i++) d[i*DW +: DW] = pk[i];
        return d;
    endfunction

    // Called at a falling edge; drives one cycle, checks outputs, advances the model.
    task automatic step(input bit vg, input bit fl, input bit rdy);
        bus.fifo_valid = vg && (src.size() != 0);
        if (bus.fifo_valid) bus.fifo_data = src[0];
        else                bus.fifo_data = {$urandom, $urandom};
        bus.flush   = fl;
        bus.m_ready = rdy;
        #1;
        chk("deque_en",  W'(bus.fifo_deque_en), W'(!hold && bus.fifo_valid));
        chk("m_valid",   W'(bus.m_valid),       W'(hold));
        chk("m_keep",    W'(bus.m_keep),        W'(exp_keep()));
        chk("m_data",    bus.m_data,            exp_data());
        chk("burst_cnt", W'(bus.burst_cnt),     W'(cnt));
        edge_n++;
        if (!hold) begin
            if (bus.fifo_valid) begin
                pk.push_back(src.pop_front());
                last_pop = edge_n;
                if ((pk.size() == BL) || fl) hold = 1'b1;
            end else if ((pk.size() != 0) && (fl || (edge_n - last_pop >= TO))) begin
                hold = 1'b1;
            end
        end else if (rdy) begin
            cnt  = cnt + 32'd1;
            pk.delete();
            hold = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge; reset takes effect without waiting for a clock edge.
    task automatic do_reset();
        bus.fifo_valid = 1'b0;
        bus.flush      = 1'b0;
        bus.m_ready    = 1'b0;
        rst_n          = 1'b0;
        #1;
        chk("rst_m_valid",   W'(bus.m_valid),   W'(0));
        chk("rst_m_keep",    W'(bus.m_keep),    W'(0));
        chk("rst_m_data",    bus.m_data,        W'(0));
        chk("rst_burst_cnt", W'(bus.burst_cnt), W'(0));
        bus.fifo_valid = 1'b1;
        #1;
        chk("rst_deque_follow", W'(bus.fifo_deque_en), W'(1));
        bus.fifo_valid = 1'b0;
        pk.delete();
        hold = 1'b0;
        cnt  = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b1;
        bus.fifo_valid = 1'b0;
        bus.fifo_data  = '0;
        bus.flush      = 1'b0;
        bus.m_ready    = 1'b0;
        hold           = 1'b0;
        cnt            = '0;
        edge_n         = 0;
        last_pop       = 0;
        @(negedge clk);
        do_reset();

        // Back-to-back full burst with immediate acceptance.
        for (int i = 1; i <= 4; i++) src.push_back(DW'(i));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);

        // Partial burst released by the idle timeout.
        src.push_back(DW'('hA));
        src.push_back(DW'('hB));
        for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b1);

        // Flush with the third pop, then flush on an empty buffer.
        for (int i = 0; i < 3; i++) src.push_back({$urandom, $urandom});
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

        // Flush on the completing pop yields one full burst.
        for (int i = 0; i < 4; i++) src.push_back({$urandom, $urandom});
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // Back-pressure: burst held for 10 cycles, more words waiting upstream.
        for (int i = 0; i < 6; i++) src.push_back({$urandom, $urandom});
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        src.delete();

        // Reset mid-burst after two pops, then a fresh burst from lane 0.
        for (int i = 0; i < 4; i++) src.push_back({$urandom, $urandom});
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 2; i++) src.push_back({$urandom, $urandom});
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if ((src.size() < 8) && ($urandom_range(0, 2) == 0)) src.push_back({$urandom, $urandom});
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
        src.delete();

        // Burst counter wrap.
        force dut.burst_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.burst_cnt_q;
        cnt = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) src.push_back({$urandom, $urandom});
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);
        chk("burst_cnt_wrap", W'(bus.burst_cnt), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
